// File: rtl/seq_mult_if.sv
// ---------------------------------------------------------------------------
// seq_mult_if
// Groups the operand, control and status signals of the signed sequential
// multiplier. Clock and reset are not part of the interface.
//   master : drives Run, ClearA_LoadB, Din; observes Aval, Bval, X, Busy, Done
//   slave  : the multiplier side of the same signals
// ---------------------------------------------------------------------------
interface seq_mult_if #(
   parameter int WIDTH = 8
);
   logic             Run;
   logic             ClearA_LoadB;
   logic [WIDTH-1:0] Din;
   logic [WIDTH-1:0] Aval;
   logic [WIDTH-1:0] Bval;
   logic             X;
   logic             Busy;
   logic             Done;

   modport master (
      output Run, ClearA_LoadB, Din,
      input  Aval, Bval, X, Busy, Done
   );

   modport slave (
      input  Run, ClearA_LoadB, Din,
      output Aval, Bval, X, Busy, Done
   );
endinterface

// File: rtl/seq_mult.sv
// ---------------------------------------------------------------------------
// seq_mult
// Signed add-shift multiplier. The multiplicand S is captured from Din at the
// start edge and the multiplier is held in B. The 2*WIDTH-bit two's-complement
// product ends up in {A, B}. One add/subtract step is followed by one
// arithmetic shift per multiplier bit; the sign bit's step subtracts instead
// of adding, which is what makes the result correct for signed operands.
//
// Ports
//   Clk      : system clock, rising edge
//   Reset_n  : asynchronous active-low reset, clears every register
//   bus      : seq_mult_if.slave
//                Run, ClearA_LoadB, Din  (inputs, only looked at in IDLE/DONE)
//                Aval, Bval, X           (register contents)
//                Busy (ADD/SHIFT), Done (DONE)
//
// Build option
//   MULT_SKIP_EN : when defined, a zero multiplier bit is shifted in the ADD
//                  cycle itself, so latency becomes WIDTH + popcount(B).
//                  Products are identical in both builds.
// ---------------------------------------------------------------------------
module seq_mult #(
   parameter int WIDTH = 8
) (
   input logic       Clk,
   input logic       Reset_n,
   seq_mult_if.slave bus
);

   localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ADD   = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                  state;
   logic signed [WIDTH-1:0] a;
   logic signed [WIDTH-1:0] b;
   logic signed [WIDTH-1:0] s;
   logic                    x;
   logic [CW-1:0]           cnt;
   logic                    busy;
   logic                    done;

   logic                    last;
   logic signed [WIDTH:0]   acc;

   // Sign-extended add or subtract, one bit wider than the operands so the
   // carry-out lands in X.
   function automatic logic signed [WIDTH:0] add_sub(
      input logic signed [WIDTH-1:0] lhs,
      input logic signed [WIDTH-1:0] rhs,
      input logic                    sub
   );
      logic signed [WIDTH:0] l_ext;
      logic signed [WIDTH:0] r_ext;
      l_ext = {lhs[WIDTH-1], lhs};
      r_ext = {rhs[WIDTH-1], rhs};
      return sub ? (l_ext - r_ext) : (l_ext + r_ext);
   endfunction

   // The last bit of a two's-complement multiplier carries weight -2^(W-1).
   assign last = (cnt == LAST);
   assign acc  = add_sub(a, s, last);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= IDLE;
         a     <= '0;
         b     <= '0;
         s     <= '0;
         x     <= 1'b0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // Loading B wins over a start request in the same cycle.
               if (bus.ClearA_LoadB) begin
                  b <= bus.Din;
                  a <= '0;
                  x <= 1'b0;
               end else if (bus.Run) begin
                  s     <= bus.Din;
                  a     <= '0;
                  x     <= 1'b0;
                  cnt   <= '0;
                  state <= ADD;
                  busy  <= 1'b1;
               end
            end

            ADD: begin
               if (b[0]) begin
                  {x, a} <= acc;
                  state  <= SHIFT;
               end else begin
`ifdef MULT_SKIP_EN
                  // Nothing to add: fold the shift into this cycle.
                  a <= {x, a[WIDTH-1:1]};
                  b <= {a[0], b[WIDTH-1:1]};
                  if (last) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
`else
                  state <= SHIFT;
`endif
               end
            end

            SHIFT: begin
               // Arithmetic right shift of {X, A, B}; X keeps the sign.
               a <= {x, a[WIDTH-1:1]};
               b <= {a[0], b[WIDTH-1:1]};
               if (last) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  cnt   <= cnt + 1'b1;
                  state <= ADD;
               end
            end

            DONE: begin
               // Product is held until Run is released.
               if (!bus.Run) begin
                  state <= IDLE;
                  done  <= 1'b0;
               end
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.Aval = a;
   assign bus.Bval = b;
   assign bus.X    = x;
   assign bus.Busy = busy;
   assign bus.Done = done;

endmodule

// File: doc/seq_mult.md
# seq_mult

Parametrised signed sequential add-shift multiplier with integrated controller and datapath. It multiplies a WIDTH-bit two's-complement multiplicand S by a WIDTH-bit multiplier held in register B, leaving the 2·WIDTH-bit product in {A, B}. It is the generalised successor of the fixed 8-bit unrolled-state multiplier controller:
- a bit counter replaces per-bit states;
- a final-step subtract gives correct signed results;
- a Done/Busy status pair is added.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32.
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Run  in  1  level start request; sampled in IDLE and DONE.
- ClearA_LoadB  in  1  in IDLE, loads B from Din and clears A and X.
- Din  in  WIDTH  operand input (switch bus).
- Aval  out  WIDTH  register A (product high half).
- Bval  out  WIDTH  register B (multiplier, then product low half).
- X  out  1  sign-extension register.
- Busy  out  1  high in ADD or SHIFT.
- Done  out  1  high in DONE.

## Operation
- Registers:
  - A, B, S: WIDTH bits each.
  - X: 1 bit.
  - cnt: $clog2(WIDTH) bits.
  - state ∈ {IDLE, ADD, SHIFT, DONE}.
- M is B[0].
- IDLE:
  - If ClearA_LoadB=1: B←Din, A←0, X←0, stay in IDLE. This has priority over Run in the same cycle.
  - Else if Run=1: S←Din, A←0, X←0, cnt←0, go to ADD. B is retained.
- ADD, M=1:
  - For cnt<WIDTH−1: {X,A} ← sext(A)+sext(S), computed at WIDTH+1 bits.
  - For cnt=WIDTH−1: {X,A} ← sext(A)−sext(S).
  - Go to SHIFT.
- ADD, M=0: A and X unchanged, go to SHIFT. The MULT_SKIP_EN variant differs; see Configuration.
- SHIFT:
  - Arithmetic right shift of {X,A,B}: A←{X,A[WIDTH−1:1]}, B←{A[0],B[WIDTH−1:1]}, X unchanged.
  - If cnt=WIDTH−1, go to DONE; else cnt←cnt+1 and go to ADD.
- DONE:
  - Product is {A,B}, signed, 2·WIDTH bits.
  - Hold all registers while Run=1; Run=0 returns to IDLE.
- Re-run without reload: the next Run multiplies the new Din by the current B, which is the previous product's low half. This is intended.
- ClearA_LoadB and Din are ignored outside IDLE. The Din sample into S happens at the start edge only.

## Timing
- Reset_n=0 forces, immediately and asynchronously, regardless of state (including mid-operation):
  - state=IDLE;
  - A=0, B=0, S=0, X=0, cnt=0;
  - Busy=0, Done=0.
- Outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- Start edge k is the edge at which IDLE samples Run=1.
- Without MULT_SKIP_EN:
  - bit i's add executes at edge k+2i+1;
  - its shift executes at edge k+2i+2;
  - Done rises after edge k+2·WIDTH;
  - Busy is high for exactly 2·WIDTH cycles.
- Run must be low for at least one sampled cycle in DONE before another operation can start.
- Run=1 and ClearA_LoadB=1 together in IDLE: the load occurs first, and the start follows at the next edge if Run is still high.

## Configuration
- MULT_SKIP_EN undefined:
  - fixed two-cycle-per-bit sequencing;
  - latency always 2·WIDTH cycles.
- MULT_SKIP_EN defined:
  - In ADD with M=0, the shift, cnt update and DONE check are performed in that same cycle, and the state stays in ADD (or goes to DONE).
  - SHIFT is entered only after an actual add or subtract.
  - Latency = WIDTH + popcount(B at start) cycles.
  - Results are identical in both builds.

## Test plan
- WIDTH=8: load B=0x03, Run with Din=0x07 → {A,B}=0x0015, X=0, Done after 16 cycles (non-skip build).
- WIDTH=8: B=0xFF, Din=0xFF (−1·−1) → {A,B}=0x0001.
- WIDTH=8: B=0x80, Din=0x80 (−128·−128) → {A,B}=0x4000. Also B=0x80, Din=0x7F → 0xC080.
- Skip build, WIDTH=8: B=0x00, Din=0x55 → product 0x0000, Done after 8 cycles. With B=0x0F, Done after 12 cycles.
- Drop Reset_n mid-operation after 5 cycles → all outputs 0 and state IDLE immediately. A subsequent load and run gives the correct product.
- WIDTH=4:
  - B=0x5, Din=0xD (5·−3) → {A,B}=0xF1.
  - Hold Run high: Done stays high and registers stay stable.
  - Second Run with Din=0x2 multiplies by B=0x1 → {A,B}=0x02.
